// File: rtl/l2_types_pkg.sv
// l2_types_pkg: shared L2 line/address geometry and the victim-buffer drain FSM state.
package l2_types_pkg;
    localparam int S_LINE = 256;
    localparam int S_ADDR = 32;
    localparam int S_OFF  = 5;

    typedef enum logic {
        IDLE,
        WRITE
    } vb_state_e;
endpackage

// File: rtl/l2_victim_buffer.sv
// l2_victim_buffer: coalescing FIFO of dirty victim lines drained to memory one write at a time,
// with a zero-latency associative lookup for miss addresses.
module l2_victim_buffer
    import l2_types_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int s_line = S_LINE,
    parameter int s_addr = S_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [s_addr-1:0] push_addr,
    input  logic [s_line-1:0] push_data,
    input  logic [s_addr-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [s_line-1:0] lookup_data,
    output logic              mem_write,
    output logic [s_addr-1:0] mem_address,
    output logic [s_line-1:0] mem_wdata,
    input  logic              mem_resp,
    output logic              empty,
    output logic              full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = s_addr - S_OFF;

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    vb_state_e         state_q, state_d;
    logic [LW-1:0]     addr_q [DEPTH];
    logic [s_line-1:0] data_q [DEPTH];

    logic [PW-1:0] idx, look_idx, push_idx, wr_idx;
    logic          push_hit, push_acc, append, pop;
    logic          unused_offsets;

    assign unused_offsets = ^{push_addr[S_OFF-1:0], lookup_addr[S_OFF-1:0]};

    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        idx        = '0;
        lookup_hit = 1'b0;
        look_idx   = '0;
        push_hit   = 1'b0;
        push_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (addr_q[idx] == lookup_addr[s_addr-1:S_OFF]) begin
                    lookup_hit = 1'b1;
                    look_idx   = idx;
                end
                if (addr_q[idx] == push_addr[s_addr-1:S_OFF] && (k != 0 || state_q == IDLE)) begin
                    push_hit = 1'b1;
                    push_idx = idx;
                end
            end
        end
    end

    assign lookup_data = lookup_hit ? data_q[look_idx] : '0;
    assign empty       = count_q == '0;
    assign full        = count_q == CW'(DEPTH);
    assign push_ready  = !full;
    assign push_acc    = push_valid && push_ready;
    assign append      = push_acc && !push_hit;
    assign pop         = state_q == WRITE && mem_resp;
    assign wr_idx      = push_hit ? push_idx : tail_q;
    assign mem_write   = state_q == WRITE;
    assign mem_address = {addr_q[head_q], {S_OFF{1'b0}}};
    assign mem_wdata   = data_q[head_q];

    always_comb begin
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = append ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(append) - CW'(pop);
        state_d = state_q == IDLE ? (empty ? IDLE : WRITE) : (mem_resp ? IDLE : WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            addr_q[wr_idx] <= push_addr[s_addr-1:S_OFF];
            data_q[wr_idx] <= push_data;
        end
    end
endmodule

// File: tb/tb_l2_victim_buffer.sv
// tb_l2_victim_buffer: directed scenarios plus randomized traffic checked against a queue model.
module tb_l2_victim_buffer;
    localparam int DEPTH = 4;
    localparam int SL    = 256;
    localparam int SA    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          push_valid, push_ready, lookup_hit, mem_write, mem_resp, empty, full;
    logic [SA-1:0] push_addr, lookup_addr, mem_address;
    logic [SL-1:0] push_data, lookup_data, mem_wdata;

    l2_victim_buffer #(.DEPTH(DEPTH), .s_line(SL), .s_addr(SA)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_addr(push_addr), .push_data(push_data),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SA-1:0] a;
        logic [SL-1:0] d;
    } ent_t;

    ent_t          mq[$];
    bit            m_wr;
    logic [SA-1:0] obs_a[$];
    logic [SL-1:0] obs_d[$];
    int            vectors = 0;
    int            errors  = 0;

    localparam logic [SL-1:0] D1 = {8{32'h1111_1111}};
    localparam logic [SL-1:0] D2 = {8{32'h2222_2222}};
    localparam logic [SL-1:0] D3 = {8{32'h3333_3333}};
    localparam logic [SL-1:0] D5 = {8{32'h5555_5555}};

    function automatic logic [SA-1:0] la(logic [SA-1:0] a);
        return a & 32'hffff_ffe0;
    endfunction

    function automatic logic [SL:0] mlook(logic [SA-1:0] a);
        logic [SL:0] r = '0;
        foreach (mq[i]) if (la(mq[i].a) == la(a)) r = {1'b1, mq[i].d};
        return r;
    endfunction

    function automatic logic [SL-1:0] rdata();
        logic [SL-1:0] r;
        for (int i = 0; i < SL / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Advance the model by the rules for the current inputs, then one clock.
    task automatic tick();
        int n = mq.size();
        int hit = -1;
        if (push_valid && n < DEPTH) begin
            for (int i = (m_wr ? 1 : 0); i < n; i++) if (la(mq[i].a) == la(push_addr)) hit = i;
            if (hit >= 0) mq[hit].d = push_data;
            else mq.push_back('{la(push_addr), push_data});
        end
        if (m_wr && mem_resp) mq.delete(0);
        m_wr = m_wr ? !mem_resp : (n > 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(logic [SA-1:0] a, logic [SL-1:0] d);
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic drain();
        obs_a.delete();
        obs_d.delete();
        push_valid = 1'b0;
        for (int c = 0; c < 60 && (mq.size() != 0 || m_wr); c++) begin
            mem_resp = m_wr;
            if (mem_write && mem_resp) begin
                obs_a.push_back(mem_address);
                obs_d.push_back(mem_wdata);
            end
            tick();
        end
        mem_resp = 1'b0;
        vectors++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        push_valid = 1'b0; push_addr = '0; push_data = '0; lookup_addr = '0; mem_resp = 1'b0;
        mq.delete(); m_wr = 1'b0;
        #1;
        vectors++;
        if ({mem_write, empty, full, push_ready, lookup_hit} !== 5'b01010 || lookup_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wr/em/fu/rdy/hit=%b data=%h want 01010 data 0",
                     {mem_write, empty, full, push_ready, lookup_hit}, lookup_data);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        push(32'h0000_1000, D1);
        vectors++;
        if (mem_write !== 1'b0) begin errors++; $display("FAIL basic_no_write_yet: got %b want 0", mem_write); end
        tick();
        vectors++;
        if (mem_write !== 1'b1 || mem_address !== 32'h0000_1000 || mem_wdata !== D1) begin
            errors++;
            $display("FAIL basic_write: got wr=%b addr=%h data=%h want 1 00001000 %h", mem_write, mem_address, mem_wdata, D1);
        end
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        vectors++;
        if (empty !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop: got empty=%b wr=%b want 1 0", empty, mem_write);
        end
    endtask

    task automatic test_full();
        mem_resp = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(32'h7000 + 32'(i) * 32'h20, rdata());
        vectors++;
        if (full !== 1'b1 || push_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_flag: got full=%b rdy=%b want 1 0", full, push_ready);
        end
        push(32'h7080, D5);
        lookup_addr = 32'h7080;
        #1;
        vectors++;
        if (full !== 1'b1 || lookup_hit !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse: got full=%b hit=%b want 1 0", full, lookup_hit);
        end
        mem_resp = 1'b1;
        push(32'h7080, D5);
        mem_resp = 1'b0;
        #1;
        vectors++;
        if (full !== 1'b0 || push_ready !== 1'b1 || lookup_hit !== 1'b0) begin
            errors++;
            $display("FAIL full_no_lookahead: got full=%b rdy=%b hit=%b want 0 1 0", full, push_ready, lookup_hit);
        end
        drain();
        vectors++;
        if (obs_a.size() != 3 || obs_a[0] !== 32'h7020 || obs_a[2] !== 32'h7060) begin
            errors++;
            $display("FAIL full_drain_order: got %0d writes want 3 (7020..7060)", obs_a.size());
        end
    endtask

    task automatic test_coalesce();
        push(32'h3000, D3);
        push(32'h2000, D1);
        push(32'h2000, D2);
        lookup_addr = 32'h2000;
        #1;
        vectors++;
        if (lookup_hit !== 1'b1 || lookup_data !== D2) begin
            errors++;
            $display("FAIL coalesce_lookup: got hit=%b data=%h want 1 %h", lookup_hit, lookup_data, D2);
        end
        drain();
        vectors++;
        if (obs_a.size() != 2 || obs_a[0] !== 32'h3000 || obs_d[0] !== D3 || obs_a[1] !== 32'h2000 || obs_d[1] !== D2) begin
            errors++;
            $display("FAIL coalesce_mem: got %0d writes want 2 (3000/D3, 2000/D2)", obs_a.size());
        end
        push(32'h8000, D1);
        push(32'h8000, D2);
        vectors++;
        if (mem_write !== 1'b1 || mem_wdata !== D2) begin
            errors++;
            $display("FAIL coalesce_idle_head: got wr=%b data=%h want 1 %h", mem_write, mem_wdata, D2);
        end
        drain();
        vectors++;
        if (obs_a.size() != 1) begin
            errors++;
            $display("FAIL coalesce_idle_count: got %0d writes want 1", obs_a.size());
        end
    endtask

    task automatic test_inflight();
        push(32'h4000, D1);
        tick();
        vectors++;
        if (mem_write !== 1'b1) begin errors++; $display("FAIL inflight_write: got %b want 1", mem_write); end
        push(32'h4000, D2);
        lookup_addr = 32'h4000;
        #1;
        vectors++;
        if (mem_wdata !== D1 || lookup_data !== D2) begin
            errors++;
            $display("FAIL inflight_data: got wdata=%h look=%h want %h %h", mem_wdata, lookup_data, D1, D2);
        end
        drain();
        vectors++;
        if (obs_a.size() != 2 || obs_d[0] !== D1 || obs_d[1] !== D2) begin
            errors++;
            $display("FAIL inflight_mem: got %0d writes want 2 (D1 then D2)", obs_a.size());
        end
    endtask

    task automatic test_lookup();
        push(32'h5000, D5);
        lookup_addr = 32'h5010;
        #1;
        vectors++;
        if (lookup_hit !== 1'b1 || lookup_data !== D5) begin
            errors++;
            $display("FAIL lookup_offset: got hit=%b data=%h want 1 %h", lookup_hit, lookup_data, D5);
        end
        lookup_addr = 32'h6000;
        #1;
        vectors++;
        if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
            errors++;
            $display("FAIL lookup_miss: got hit=%b data=%h want 0 0", lookup_hit, lookup_data);
        end
        drain();
    endtask

    task automatic test_reset_midwrite();
        for (int i = 0; i < 3; i++) push(32'hA000 + 32'(i) * 32'h20, rdata());
        vectors++;
        if (mem_write !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got wr=%b want 1", mem_write); end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (mem_write !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || push_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_abort: got wr=%b empty=%b full=%b rdy=%b want 0 1 0 1", mem_write, empty, full, push_ready);
        end
        mq.delete(); m_wr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stray_resp: got empty=%b full=%b wr=%b want 1 0 0", empty, full, mem_write);
        end
        push(32'hB000, D3);
        drain();
        vectors++;
        if (obs_a.size() != 1 || obs_a[0] !== 32'hB000 || obs_d[0] !== D3) begin
            errors++;
            $display("FAIL rstmid_recover: got %0d writes want 1 (B000/D3)", obs_a.size());
        end
    endtask

    task automatic test_random();
        logic [SL:0] exp_l;
        for (int c = 0; c < 800; c++) begin
            push_valid  = ($urandom_range(0, 1) == 1);
            push_addr   = 32'h9000 + 32'($urandom_range(0, 5)) * 32'h20 + 32'($urandom_range(0, 31));
            push_data   = rdata();
            lookup_addr = 32'h9000 + 32'($urandom_range(0, 6)) * 32'h20 + 32'($urandom_range(0, 31));
            mem_resp    = ($urandom_range(0, 9) < 3);
            #1;
            exp_l = mlook(lookup_addr);
            vectors++;
            if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) || push_ready !== (mq.size() < DEPTH)) begin
                errors++;
                $display("FAIL rand_flags c=%0d: got empty=%b full=%b rdy=%b want size %0d", c, empty, full, push_ready, mq.size());
            end
            vectors++;
            if (lookup_hit !== exp_l[SL] || lookup_data !== exp_l[SL-1:0]) begin
                errors++;
                $display("FAIL rand_lookup c=%0d: got hit=%b data=%h want %b %h", c, lookup_hit, lookup_data, exp_l[SL], exp_l[SL-1:0]);
            end
            vectors++;
            if (mem_write !== m_wr) begin
                errors++;
                $display("FAIL rand_mem_write c=%0d: got %b want %b", c, mem_write, m_wr);
            end else if (m_wr) begin
                vectors++;
                if (mem_address !== mq[0].a || mem_wdata !== mq[0].d) begin
                    errors++;
                    $display("FAIL rand_mem_head c=%0d: got %h/%h want %h/%h", c, mem_address, mem_wdata, mq[0].a, mq[0].d);
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_coalesce();
        test_inflight();
        test_lookup();
        test_reset_midwrite();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
